// File: rtl/keyboard_decoder.sv
// PS/2 scan-code set 2 decoder producing single editing commands for the text buffer.
// Tracks E0/F0 prefixes and shift keys, holds a command until acknowledged, counts lost make codes.
module keyboard_decoder #(
    parameter int SYMBOL_WIDTH     = 7,
    parameter int DROP_COUNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  scancode,
    input  logic                        scancode_valid,
    output logic                        left,
    output logic                        right,
    output logic                        backspace,
    output logic [SYMBOL_WIDTH-1:0]     symbol,
    input  logic                        input_ready,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_SHIFTL = 8'h12;
    localparam logic [7:0] CODE_SHIFTR = 8'h59;
    localparam logic [DROP_COUNT_WIDTH-1:0] DROP_MAX = {DROP_COUNT_WIDTH{1'b1}};

    // Lowercase ASCII for a letter key, 0 when the code is not a letter.
    function automatic logic [6:0] letter_ascii(input logic [7:0] code);
        logic [6:0] a;
        case (code)
            8'h1C: a = 7'h61;  8'h32: a = 7'h62;  8'h21: a = 7'h63;  8'h23: a = 7'h64;
            8'h24: a = 7'h65;  8'h2B: a = 7'h66;  8'h34: a = 7'h67;  8'h33: a = 7'h68;
            8'h43: a = 7'h69;  8'h3B: a = 7'h6A;  8'h42: a = 7'h6B;  8'h4B: a = 7'h6C;
            8'h3A: a = 7'h6D;  8'h31: a = 7'h6E;  8'h44: a = 7'h6F;  8'h4D: a = 7'h70;
            8'h15: a = 7'h71;  8'h2D: a = 7'h72;  8'h1B: a = 7'h73;  8'h2C: a = 7'h74;
            8'h3C: a = 7'h75;  8'h2A: a = 7'h76;  8'h1D: a = 7'h77;  8'h22: a = 7'h78;
            8'h35: a = 7'h79;  8'h1A: a = 7'h7A;
            default: a = 7'h00;
        endcase
        return a;
    endfunction

    // Unshifted ASCII digit for a number-row key, 0 when the code is not a digit.
    function automatic logic [6:0] digit_ascii(input logic [7:0] code);
        logic [6:0] a;
        case (code)
            8'h45: a = 7'h30;  8'h16: a = 7'h31;  8'h1E: a = 7'h32;  8'h26: a = 7'h33;
            8'h25: a = 7'h34;  8'h2E: a = 7'h35;  8'h36: a = 7'h36;  8'h3D: a = 7'h37;
            8'h3E: a = 7'h38;  8'h46: a = 7'h39;
            default: a = 7'h00;
        endcase
        return a;
    endfunction

    // Result packing: {valid, left, right, backspace, symbol[6:0]}.
    function automatic logic [10:0] decode(input logic [7:0] code, input logic ext,
                                           input logic shift);
        logic       l, r, b;
        logic [6:0] s, lt, dg;
        l  = 1'b0;
        r  = 1'b0;
        b  = 1'b0;
        s  = 7'h00;
        lt = letter_ascii(code);
        dg = digit_ascii(code);
        if (ext) begin
            case (code)
                8'h6B:   l = 1'b1;
                8'h74:   r = 1'b1;
                8'h4A:   s = 7'h2F;
                default: s = 7'h00;
            endcase
        end else if (code == 8'h66) begin
            b = 1'b1;
        end else if (lt != 7'h00) begin
            s = shift ? (lt - 7'h20) : lt;
        end else if (dg != 7'h00) begin
            if (!shift) begin
                s = dg;
            end else begin
                case (code)
                    8'h3E:   s = 7'h2A;
                    8'h36:   s = 7'h5E;
                    8'h46:   s = 7'h28;
                    8'h45:   s = 7'h29;
                    default: s = 7'h00;
                endcase
            end
        end else begin
            case (code)
                8'h4E:   s = 7'h2D;
                8'h55:   s = shift ? 7'h2B : 7'h3D;
                8'h4A:   s = 7'h2F;
                8'h49:   s = 7'h2E;
                8'h29:   s = 7'h20;
                default: s = 7'h00;
            endcase
        end
        return {(l | r | b | (s != 7'h00)), l, r, b, s};
    endfunction

    state_t                      state_q, state_d;
    logic                        ext_q, ext_d;
    logic                        brk_q, brk_d;
    logic                        shift_l_q, shift_l_d;
    logic                        shift_r_q, shift_r_d;
    logic                        left_q, left_d;
    logic                        right_q, right_d;
    logic                        backspace_q, backspace_d;
    logic [SYMBOL_WIDTH-1:0]     symbol_q, symbol_d;
    logic [DROP_COUNT_WIDTH-1:0] drop_q, drop_d;

    logic        final_s;
    logic        cmd_s;
    logic [10:0] dec_s;

    // Prefix/shift tracking, command decode and pending-command FSM.
    always_comb begin
        state_d     = state_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        left_d      = left_q;
        right_d     = right_q;
        backspace_d = backspace_q;
        symbol_d    = symbol_q;
        drop_d      = drop_q;

        final_s = scancode_valid && (scancode != CODE_EXT) && (scancode != CODE_BRK);
        dec_s   = decode(scancode, ext_q, shift_l_q | shift_r_q);
        cmd_s   = final_s && !brk_q && dec_s[10];

        if (scancode_valid) begin
            if (scancode == CODE_EXT) begin
                ext_d = 1'b1;
            end else if (scancode == CODE_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                // A shift key's make sets and its break clears, regardless of pending state.
                if (scancode == CODE_SHIFTL) begin
                    shift_l_d = !brk_q;
                end else if (scancode == CODE_SHIFTR) begin
                    shift_r_d = !brk_q;
                end else begin
                    shift_l_d = shift_l_q;
                end
            end
        end else begin
            ext_d = ext_q;
        end

        case (state_q)
            IDLE: begin
                if (cmd_s) begin
                    left_d      = dec_s[9];
                    right_d     = dec_s[8];
                    backspace_d = dec_s[7];
                    symbol_d    = SYMBOL_WIDTH'(dec_s[6:0]);
                    state_d     = PENDING;
                end else begin
                    state_d = IDLE;
                end
            end
            PENDING: begin
                if (cmd_s && (drop_q != DROP_MAX)) begin
                    drop_d = drop_q + DROP_COUNT_WIDTH'(1);
                end else begin
                    drop_d = drop_q;
                end
                if (input_ready) begin
                    left_d      = 1'b0;
                    right_d     = 1'b0;
                    backspace_d = 1'b0;
                    symbol_d    = '0;
                    state_d     = IDLE;
                end else begin
                    state_d = PENDING;
                end
            end
            default: begin
                left_d      = 1'b0;
                right_d     = 1'b0;
                backspace_d = 1'b0;
                symbol_d    = '0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            backspace_q <= 1'b0;
            symbol_q    <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            left_q      <= left_d;
            right_q     <= right_d;
            backspace_q <= backspace_d;
            symbol_q    <= symbol_d;
            drop_q      <= drop_d;
        end
    end

    assign left       = left_q;
    assign right      = right_q;
    assign backspace  = backspace_q;
    assign symbol     = symbol_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_keyboard_decoder.sv
// Self-checking bench for keyboard_decoder: directed scenarios plus randomized byte streams
// compared against a table-driven behavioural model.
module tb_keyboard_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] scancode = 8'h00;
    logic       scancode_valid = 1'b0;
    logic       input_ready = 1'b0;
    logic       left, right, backspace;
    logic [6:0] symbol;
    logic [7:0] drop_count;

    int checks = 0;
    int failures = 0;

    keyboard_decoder #(.SYMBOL_WIDTH(7), .DROP_COUNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .scancode(scancode), .scancode_valid(scancode_valid),
        .left(left), .right(right), .backspace(backspace), .symbol(symbol),
        .input_ready(input_ready), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                     8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                     8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                     8'h35, 8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                     8'h3E, 8'h46};
    logic [7:0] pool [24] = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h6B, 8'h74, 8'h66, 8'h1C, 8'h1A,
                              8'h3E, 8'h36, 8'h46, 8'h45, 8'h16, 8'h55, 8'h4E, 8'h4A, 8'h49,
                              8'h29, 8'h07, 8'h4D, 8'h26, 8'hF0, 8'hE0};

    // Reference state: kind 0 none, 1 left, 2 right, 3 backspace, 4 symbol.
    bit         m_ext, m_brk, m_shl, m_shr, m_pend;
    int         m_kind;
    logic [6:0] m_sym;
    int         m_drop;

    function automatic void ref_lookup(input logic [7:0] code, input bit ext, input bit shift,
                                       output int kind, output logic [6:0] s);
        kind = 0;
        s    = 7'h00;
        if (ext) begin
            if (code == 8'h6B) kind = 1;
            if (code == 8'h74) kind = 2;
            if (code == 8'h4A) begin kind = 4; s = "/"; end
        end else begin
            if (code == 8'h66) kind = 3;
            for (int i = 0; i < 26; i++)
                if (letter_codes[i] == code) begin
                    kind = 4;
                    s = 7'((shift ? 8'd65 : 8'd97) + 8'(i));
                end
            for (int d = 0; d < 10; d++)
                if (digit_codes[d] == code) begin
                    if (!shift) begin kind = 4; s = 7'(8'd48 + 8'(d)); end
                    else if (d == 8) begin kind = 4; s = "*"; end
                    else if (d == 6) begin kind = 4; s = "^"; end
                    else if (d == 9) begin kind = 4; s = "("; end
                    else if (d == 0) begin kind = 4; s = ")"; end
                end
            if (code == 8'h4E) begin kind = 4; s = "-"; end
            if (code == 8'h55) begin kind = 4; s = shift ? "+" : "="; end
            if (code == 8'h4A) begin kind = 4; s = "/"; end
            if (code == 8'h49) begin kind = 4; s = "."; end
            if (code == 8'h29) begin kind = 4; s = " "; end
        end
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_pend = 0; m_kind = 0; m_sym = 0; m_drop = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] code, input logic rdy);
        int kind = 0;
        logic [6:0] s = 7'h00;
        if (v) begin
            if (code == 8'hE0) m_ext = 1;
            else if (code == 8'hF0) m_brk = 1;
            else begin
                if (m_brk) begin
                    if (code == 8'h12) m_shl = 0;
                    if (code == 8'h59) m_shr = 0;
                end else if (code == 8'h12) m_shl = 1;
                else if (code == 8'h59) m_shr = 1;
                else ref_lookup(code, m_ext, m_shl | m_shr, kind, s);
                m_ext = 0;
                m_brk = 0;
            end
        end
        if (m_pend) begin
            if (kind != 0 && m_drop < 255) m_drop++;
            if (rdy) m_pend = 0;
        end else if (kind != 0) begin
            m_pend = 1; m_kind = kind; m_sym = s;
        end
    endtask

    function automatic logic [17:0] exp_vec();
        return {m_pend && m_kind == 1, m_pend && m_kind == 2, m_pend && m_kind == 3,
                (m_pend && m_kind == 4) ? m_sym : 7'h00, 8'(m_drop)};
    endfunction

    function automatic logic [17:0] obs_vec();
        return {left, right, backspace, symbol, drop_count};
    endfunction

    task automatic drive(input logic v, input logic [7:0] code, input logic rdy);
        scancode_valid = v;
        scancode       = code;
        input_ready    = rdy;
        @(posedge clk);
        model_step(v, code, rdy);
        #1;
        scancode_valid = 1'b0;
        input_ready    = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        checks++;
        if (obs_vec() !== 18'h0) begin
            failures++; $display("FAIL reset_during obs=%h exp=%h", obs_vec(), 18'h0);
        end
        @(negedge clk); rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL reset_after obs=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_letter_ack();
        drive(1'b1, 8'h1C, 1'b0);
        checks++;
        if (symbol !== 7'h61) begin
            failures++; $display("FAIL letter_latency symbol=%h exp=61", symbol);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b0);
            checks++;
            if (obs_vec() !== exp_vec() || symbol !== 7'h61) begin
                failures++; $display("FAIL letter_hold obs=%h exp=%h", obs_vec(), exp_vec());
            end
        end
        drive(1'b0, 8'h00, 1'b1);
        checks++;
        if (symbol !== 7'h00 || obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL letter_ack obs=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_shift();
        logic [7:0] seq [6] = '{8'h12, 8'h3E, 8'h00, 8'hF0, 8'h12, 8'h3E};
        logic [6:0] want [6] = '{7'h00, 7'h2A, 7'h00, 7'h00, 7'h00, 7'h38};
        for (int i = 0; i < 6; i++) begin
            if (seq[i] == 8'h00) drive(1'b0, 8'h00, 1'b0);
            else drive(1'b1, seq[i], 1'b0);
            checks++;
            if (symbol !== want[i] || obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL shift_seq[%0d] symbol=%h exp=%h", i, symbol, want[i]);
            end
            if (want[i] != 7'h00) drive(1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_nav();
        logic [7:0] seq [5] = '{8'hE0, 8'h6B, 8'hE0, 8'h74, 8'h66};
        logic [2:0] want [5] = '{3'b000, 3'b100, 3'b000, 3'b010, 3'b001};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq[i], 1'b0);
            checks++;
            if ({left, right, backspace} !== want[i] || obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL nav[%0d] lrb=%b exp=%b", i, {left, right, backspace}, want[i]);
            end
            if (want[i] != 3'b000) begin
                drive(1'b0, 8'h00, 1'b0);
                checks++;
                if ({left, right, backspace} !== want[i]) begin
                    failures++; $display("FAIL nav_hold[%0d] lrb=%b exp=%b", i,
                                         {left, right, backspace}, want[i]);
                end
                drive(1'b0, 8'h00, 1'b1);
            end
        end
    endtask

    task automatic test_ignored();
        logic [7:0] seq [6] = '{8'hF0, 8'h1C, 8'hE0, 8'hF0, 8'h6B, 8'h07};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, seq[i], 1'b0);
            checks++;
            if (obs_vec() !== 18'h0 || obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL ignored[%0d] obs=%h exp=0", i, obs_vec());
            end
        end
    endtask

    task automatic test_drop();
        drive(1'b1, 8'h16, 1'b0);
        drive(1'b1, 8'h1E, 1'b0);
        checks++;
        if (symbol !== 7'h31 || drop_count !== 8'd1) begin
            failures++; $display("FAIL drop_one symbol=%h drop=%0d exp 31/1", symbol, drop_count);
        end
        for (int i = 0; i < 300; i++) drive(1'b1, 8'h1E, 1'b0);
        checks++;
        if (drop_count !== 8'd255 || obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL drop_saturate drop=%0d exp=255", drop_count);
        end
        drive(1'b1, 8'h1E, 1'b1);
        checks++;
        if (obs_vec() !== exp_vec() || symbol !== 7'h00) begin
            failures++; $display("FAIL drop_ack_collide obs=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'h45, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs_vec() !== 18'h0) begin
            failures++; $display("FAIL reset_mid obs=%h exp=0", obs_vec());
        end
        @(negedge clk); rst_n = 1'b1;
        drive(1'b1, 8'h45, 1'b0);
        checks++;
        if (symbol !== 7'h30 || obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL reset_release symbol=%h exp=30", symbol);
        end
        drive(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_random();
        logic       v, rdy;
        logic [7:0] code;
        int         bad = 0;
        for (int i = 0; i < 4000; i++) begin
            v    = ($urandom_range(0, 99) < 70);
            rdy  = ($urandom_range(0, 99) < 25);
            code = ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 23)];
            drive(v, code, rdy);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                if (bad < 10) $display("FAIL random[%0d] obs=%h exp=%h", i, obs_vec(), exp_vec());
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_letter_ack();
        test_shift();
        test_nav();
        test_ignored();
        test_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
